// File: rtl/mem_req_rsp_fifo_pkg.sv
// Shared request/response types for the master <-> slave memory buffer.
// A request is packed as {cmd, addr[26:0], data[127:0]} = 156 bits.
package master_fifo_slave;

    localparam int REQ_W = 156;
    localparam int RSP_W = 128;

    typedef enum logic {
        CMD_WRITE = 1'b0,
        CMD_READ  = 1'b1
    } cmd_e;

    typedef struct packed {
        cmd_e         cmd;
        logic [26:0]  addr;
        logic [127:0] data;
    } request;

    typedef logic [RSP_W-1:0] response;

endpackage

// File: rtl/mem_req_rsp_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: o_dout is the head entry whenever !o_empty.
// Callers must not push when full or pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/mem_req_rsp_fifo.sv
// Request/response buffer between a memory master and slave, with read-credit flow control.
// Define MEM_FIFO_STATS_EN to add the stat_rd_cnt/stat_wr_cnt/stat_stall_cnt outputs.
module mem_req_rsp_fifo
    import master_fifo_slave::*;
#(
    parameter int REQ_DEPTH = 8,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  request      m_req,
    input  logic        m_req_en,
    output logic        m_req_rdy,
    output response     m_rsp,
    output logic        m_rsp_en,
    input  logic        m_rsp_rdy,
    output request      s_req,
    output logic        s_req_en,
    input  logic        s_req_rdy,
    input  response     s_rsp,
    input  logic        s_rsp_en,
    output logic        s_rsp_rdy
`ifdef MEM_FIFO_STATS_EN
    ,
    output logic [31:0] stat_rd_cnt,
    output logic [31:0] stat_wr_cnt,
    output logic [31:0] stat_stall_cnt
`endif
);

    localparam int RAW = $clog2(REQ_DEPTH);
    localparam int CW  = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX  = CW'(RSP_DEPTH);
    localparam logic [RAW:0]  REQ_CNT_MAX = (RAW+1)'(REQ_DEPTH);

    logic          w_req_push, w_req_pop, w_rsp_push, w_rsp_pop, w_rd_acc;
    logic          w_req_full, w_req_empty, w_rsp_full, w_rsp_empty;
    logic [RAW:0]  w_req_count;
    logic [CW-1:0] w_rsp_count;
    logic [REQ_W-1:0] w_req_head;
    logic [CW-1:0] r_credit;

    assign w_req_push = m_req_en && m_req_rdy;
    assign w_req_pop  = s_req_en && s_req_rdy;
    assign w_rsp_push = s_rsp_en && s_rsp_rdy;
    assign w_rsp_pop  = m_rsp_en && m_rsp_rdy;
    assign w_rd_acc   = w_req_push && (m_req.cmd == CMD_READ);

    // Handshake outputs are gated by rst_n so they drop the moment reset asserts.
    assign m_req_rdy = rst_n && !w_req_full && (r_credit != '0);
    assign s_req_en  = rst_n && !w_req_empty;
    assign s_rsp_rdy = rst_n && !w_rsp_full;
    assign m_rsp_en  = rst_n && !w_rsp_empty;
    assign s_req     = request'(w_req_head);

    sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_push),
        .i_din   (m_req),
        .i_pop   (w_req_pop),
        .o_dout  (w_req_head),
        .o_full  (w_req_full),
        .o_empty (w_req_empty),
        .o_count (w_req_count)
    );

    sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rsp_push),
        .i_din   (s_rsp),
        .i_pop   (w_rsp_pop),
        .o_dout  (m_rsp),
        .o_full  (w_rsp_full),
        .o_empty (w_rsp_empty),
        .o_count (w_rsp_count)
    );

    // One credit per response slot: taken by an accepted read, returned when its response leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit <= CREDIT_MAX;
        end else begin
            case ({w_rd_acc, w_rsp_pop})
                2'b10:   r_credit <= r_credit - 1'b1;
                2'b01:   r_credit <= r_credit + 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

`ifdef MEM_FIFO_STATS_EN
    logic [31:0] r_stat_rd, r_stat_wr, r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_rd    <= '0;
            r_stat_wr    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_rd_acc)                          r_stat_rd    <= r_stat_rd + 1'b1;
            if (w_req_push && !w_rd_acc)           r_stat_wr    <= r_stat_wr + 1'b1;
            if (m_req_en && !m_req_rdy)            r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_rd_cnt    = r_stat_rd;
    assign stat_wr_cnt    = r_stat_wr;
    assign stat_stall_cnt = r_stat_stall;
`endif

    logic [CW:0] w_slots_used;
    assign w_slots_used = {1'b0, r_credit} + {1'b0, w_rsp_count};

    a_rsp_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(s_rsp_en && w_rsp_full));
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_slots_used <= {1'b0, CREDIT_MAX});
    a_req_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_req_count <= REQ_CNT_MAX);

endmodule

// File: tb/tb_mem_req_rsp_fifo.sv
// Self-checking bench for mem_req_rsp_fifo: queue-level reference model, per-cycle compare, directed vectors.
module tb_mem_req_rsp_fifo;
    import master_fifo_slave::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    request  m_req = '0;
    logic    m_req_en = 1'b0;
    logic    m_req_rdy;
    response m_rsp;
    logic    m_rsp_en;
    logic    m_rsp_rdy = 1'b0;
    request  s_req;
    logic    s_req_en;
    logic    s_req_rdy = 1'b0;
    response s_rsp = '0;
    logic    s_rsp_en = 1'b0;
    logic    s_rsp_rdy;
`ifdef MEM_FIFO_STATS_EN
    logic [31:0] stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_req_rsp_fifo #(.REQ_DEPTH(8), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_req_en(m_req_en), .m_req_rdy(m_req_rdy),
        .m_rsp(m_rsp), .m_rsp_en(m_rsp_en), .m_rsp_rdy(m_rsp_rdy),
        .s_req(s_req), .s_req_en(s_req_en), .s_req_rdy(s_req_rdy),
        .s_rsp(s_rsp), .s_rsp_en(s_rsp_en), .s_rsp_rdy(s_rsp_rdy)
`ifdef MEM_FIFO_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain queues plus an outstanding-read budget.
    request        req_q[$];
    response       rsp_q[$];
    logic [26:0]   slv_rd_q[$];
    int            credit = 4;
    bit            acc_req = 0, acc_rsp = 0;
    bit            f_mreq, f_sreq, f_srsp, f_mrsp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q.delete(); rsp_q.delete(); slv_rd_q.delete();
            credit = 4; acc_req = 0; acc_rsp = 0;
        end else begin
            f_mreq = m_req_en && (req_q.size() < 8) && (credit > 0);
            f_sreq = (req_q.size() > 0) && s_req_rdy;
            f_srsp = s_rsp_en && (rsp_q.size() < 4);
            f_mrsp = (rsp_q.size() > 0) && m_rsp_rdy;
            if (f_sreq) begin
                if (req_q[0].cmd == CMD_READ) slv_rd_q.push_back(req_q[0].addr);
                void'(req_q.pop_front());
            end
            if (f_mreq) req_q.push_back(m_req);
            if (f_mrsp) void'(rsp_q.pop_front());
            if (f_srsp) begin
                rsp_q.push_back(s_rsp);
                if (slv_rd_q.size() > 0) void'(slv_rd_q.pop_front());
            end
            if (f_mreq && m_req.cmd == CMD_READ) credit--;
            if (f_mrsp) credit++;
            acc_req = f_mreq;
            acc_rsp = f_srsp;
        end
    end

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m_req_rdy", m_req_rdy, 1'b0);
            chk("rst_s_req_en",  s_req_en,  1'b0);
            chk("rst_s_rsp_rdy", s_rsp_rdy, 1'b0);
            chk("rst_m_rsp_en",  m_rsp_en,  1'b0);
        end else begin
            chk("m_req_rdy", m_req_rdy, (req_q.size() < 8) && (credit > 0));
            chk("s_req_en",  s_req_en,  req_q.size() > 0);
            if (req_q.size() > 0) chk("s_req", s_req, req_q[0]);
            chk("s_rsp_rdy", s_rsp_rdy, rsp_q.size() < 4);
            chk("m_rsp_en",  m_rsp_en,  rsp_q.size() > 0);
            if (rsp_q.size() > 0) chk("m_rsp", m_rsp, rsp_q[0]);
        end
    end

    function automatic request mk(input bit c, input logic [26:0] a, input logic [127:0] d);
        request r;
        r.cmd  = cmd_e'(c);
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    function automatic response rsp_data(input logic [26:0] a);
        return {4{5'b10101, a}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        m_req_en = 0; s_req_rdy = 1; m_rsp_rdy = 1;
        while ((req_q.size() + rsp_q.size() + slv_rd_q.size()) > 0 && n < 200) begin
            s_rsp_en = slv_rd_q.size() > 0;
            if (s_rsp_en) s_rsp = rsp_data(slv_rd_q[0]);
            tick();
            n++;
        end
        s_rsp_en = 0; m_rsp_rdy = 0;
        chk("drain_in_budget", n < 200, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [26:0] addr_ctr;

    initial begin
        // 1: reset and idle state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_rdy_in_reset", m_req_rdy, 1'b0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("t1_m_req_rdy", m_req_rdy, 1'b1);
        chk("t1_s_req_en",  s_req_en,  1'b0);
        chk("t1_m_rsp_en",  m_rsp_en,  1'b0);
        chk("t1_s_rsp_rdy", s_rsp_rdy, 1'b1);
        tick();

        // 2: fill request FIFO with 8 writes, then drain in order
        s_req_rdy = 0;
        for (int i = 0; i < 8; i++) begin
            m_req_en = 1; m_req = mk(0, 27'(i), 128'(i + 'hA0));
            tick();
        end
        m_req_en = 0;
        @(negedge clk);
        chk("t2_full_rdy", m_req_rdy, 1'b0);
        tick();
        s_req_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_out_en", s_req_en, 1'b1);
            chk("t2_out_data", s_req.data, 128'(i + 'hA0));
            tick();
        end
        @(negedge clk);
        chk("t2_empty", s_req_en, 1'b0);
        tick();

        // 3: four reads exhaust credit; one returned response releases the stall
        for (int i = 0; i < 4; i++) begin
            m_req_en = 1; m_req = mk(1, 27'('h10 + i), '0);
            tick();
        end
        m_req = mk(0, 27'h20, 128'h55);
        @(negedge clk);
        chk("t3_stall_a", m_req_rdy, 1'b0);
        tick();
        @(negedge clk);
        chk("t3_stall_b", m_req_rdy, 1'b0);
        s_rsp_en = 1; s_rsp = rsp_data(slv_rd_q[0]); m_rsp_rdy = 1;
        tick();
        s_rsp_en = 0;
        @(negedge clk);
        chk("t3_still_stalled", m_req_rdy, 1'b0);
        tick();
        @(negedge clk);
        chk("t3_released", m_req_rdy, 1'b1);
        tick();
        m_req_en = 0;
        drain();

        // 4: read 0x100, response latency and hold
        s_req_rdy = 1;
        m_req_en = 1; m_req = mk(1, 27'h100, '0);
        tick();
        m_req_en = 0;
        tick(); tick();
        m_rsp_rdy = 0; s_rsp_en = 1; s_rsp = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        @(negedge clk);
        chk("t4_no_bypass", m_rsp_en, 1'b0);
        tick();
        s_rsp_en = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_rsp_en", m_rsp_en, 1'b1);
            chk("t4_rsp_data", m_rsp, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF);
            tick();
        end
        m_rsp_rdy = 1;
        tick();
        m_rsp_rdy = 0;
        @(negedge clk);
        chk("t4_popped", m_rsp_en, 1'b0);

        // 5: simultaneous response pop and read accept at credit 1
        for (int i = 0; i < 3; i++) begin
            m_req_en = 1; m_req = mk(1, 27'('h200 + i), '0);
            tick();
        end
        m_req_en = 0;
        tick(); tick();
        s_rsp_en = 1; s_rsp = rsp_data(slv_rd_q[0]);
        tick();
        s_rsp_en = 0;
        m_req_en = 1; m_req = mk(1, 27'h300, '0); m_rsp_rdy = 1;
        @(negedge clk);
        chk("t5_rdy_at_credit1", m_req_rdy, 1'b1);
        chk("t5_rsp_ready", m_rsp_en, 1'b1);
        tick();
        m_req = mk(1, 27'h301, '0); m_rsp_rdy = 0;
        @(negedge clk);
        chk("t5_credit_kept", m_req_rdy, 1'b1);
        tick();
        m_req_en = 0;
        @(negedge clk);
        chk("t5_credit_zero", m_req_rdy, 1'b0);
        drain();

        // 5b: random soak, model checks every cycle
        addr_ctr = 27'h1000;
        for (int c = 0; c < 400; c++) begin
            if (!m_req_en || acc_req) begin
                m_req_en = ($urandom_range(0, 9) < 6);
                m_req = mk(1'($urandom_range(0, 1)), addr_ctr, {$urandom, $urandom, $urandom, $urandom});
                addr_ctr = addr_ctr + 1'b1;
            end
            s_req_rdy = 1'($urandom_range(0, 1));
            m_rsp_rdy = 1'($urandom_range(0, 1));
            if (!s_rsp_en || acc_rsp) begin
                s_rsp_en = (slv_rd_q.size() > 0) && ($urandom_range(0, 1) == 1);
                if (s_rsp_en) s_rsp = rsp_data(slv_rd_q[0]);
            end
            tick();
        end
        m_req_en = 0; s_rsp_en = 0;
        drain();

        // 6: asynchronous reset with entries queued
        s_req_rdy = 1;
        m_req_en = 1; m_req = mk(1, 27'h400, '0);
        tick();
        m_req_en = 0;
        tick(); tick();
        s_rsp_en = 1; s_rsp = rsp_data(slv_rd_q[0]); m_rsp_rdy = 0;
        tick();
        s_rsp_en = 0; s_req_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            m_req_en = 1; m_req = mk(i < 2, 27'('h410 + i), 128'(i));
            tick();
        end
        m_req_en = 0;
        @(negedge clk);
        chk("t6_pre_s_req_en", s_req_en, 1'b1);
        chk("t6_pre_m_rsp_en", m_rsp_en, 1'b1);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("t6_async_m_req_rdy", m_req_rdy, 1'b0);
        chk("t6_async_s_req_en",  s_req_en,  1'b0);
        chk("t6_async_s_rsp_rdy", s_rsp_rdy, 1'b0);
        chk("t6_async_m_rsp_en",  m_rsp_en,  1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("t6_post_m_req_rdy", m_req_rdy, 1'b1);
        chk("t6_post_s_req_en",  s_req_en,  1'b0);
        chk("t6_post_m_rsp_en",  m_rsp_en,  1'b0);
        tick();
        // credit back at 4: one write, four reads, then three stalled cycles
        s_req_rdy = 1;
        m_req_en = 1; m_req = mk(0, 27'h500, 128'h77);
        tick();
        for (int i = 0; i < 4; i++) begin
            m_req = mk(1, 27'('h510 + i), '0);
            tick();
        end
        m_req = mk(1, 27'h520, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_credit4_stall", m_req_rdy, 1'b0);
            tick();
        end
        m_req_en = 0;
`ifdef MEM_FIFO_STATS_EN
        @(negedge clk);
        chk("stat_rd",    stat_rd_cnt,    32'd4);
        chk("stat_wr",    stat_wr_cnt,    32'd1);
        chk("stat_stall", stat_stall_cnt, 32'd3);
`endif
        drain();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
